// File: rtl/wb_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter_if
//
// One Wishbone point-to-point link: the signal bundle between a bus master
// and the thing it talks to. The arbiter uses three instances of it: one
// per upstream master (the arbiter is their slave) and one towards the
// shared slave bus (the arbiter is its master).
//
// Signals (named from the master's point of view):
//   cyc, stb, we   master -> slave  cycle, strobe, write enable
//   adr[15:0]      master -> slave  address (top 4 bits select the slave)
//   dat_o[7:0]     master -> slave  write data
//   dat_i[7:0]     slave  -> master read data
//   ack            slave  -> master transfer acknowledge
//   err            slave  -> master error / watchdog pulse
//
// Modports:
//   master  drives cyc/stb/we/adr/dat_o, receives dat_i/ack/err
//   slave   receives cyc/stb/we/adr/dat_o, drives dat_i/ack/err
// ---------------------------------------------------------------------------
interface wb_bus_arbiter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [7:0]  dat_o;
  logic [7:0]  dat_i;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, adr, dat_o,
    input  dat_i, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_o,
    output dat_i, ack, err
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter
//
// Two-master Wishbone arbiter in front of the shared slave bus. Master 0 is
// the CPU-side master, master 1 a secondary (DMA / test) master. Grants are
// round-robin and held for the owner's whole cyc; there is no preemption.
// Every hand-over passes through one IDLE cycle, so the shared bus always
// sees a one-cycle gap between owners.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   m0       master 0 link (slave modport: we receive its requests)
//   m1       master 1 link (slave modport)
//   wb       shared bus link (master modport: we drive the slaves)
//   gnt[1:0] one-hot current owner, 00 when idle
//
// Parameters:
//   TIMEOUT  cycles of stb-without-ack before the watchdog fires (2..255)
//   TO_W     watchdog counter width, 2**TO_W must exceed TIMEOUT
//
// Build option:
//   WB_ARB_TIMEOUT_EN  when defined, adds the no-ack watchdog: after
//   TIMEOUT stalled cycles the owner receives a one-cycle err pulse and the
//   bus is parked (cyc/stb low) in TOUT until the owner drops cyc. When
//   undefined there is no counter and m*.err are constant 0, so a slave
//   that never acks stalls the bus indefinitely.
// ---------------------------------------------------------------------------
module wb_bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  wb_bus_arbiter_if.slave  m0,
  wb_bus_arbiter_if.slave  m1,
  wb_bus_arbiter_if.master wb,
  output logic [1:0]       gnt
);

  // Elaboration-time guard on the parameter ranges.
  generate
    if (TIMEOUT < 2 || TIMEOUT > 255 || TO_W < 1 || TO_W > 30 ||
        (1 << TO_W) <= TIMEOUT) begin : g_bad_params
      $error("wb_bus_arbiter: illegal TIMEOUT/TO_W combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
`ifdef WB_ARB_TIMEOUT_EN
    ,
    TOUT = 2'd3
`endif
  } state_t;

  state_t      state_reg;
  logic        last_reg;   // master that owned the bus most recently
  logic [1:0]  gnt_reg;

  // Index of the master currently holding the bus. In TOUT the offender is
  // the one recorded in last_reg on entry.
  logic        own_sel;
  logic        own_cyc;
  // Which master the shared bus is actually connected to (never in TOUT).
  logic [1:0]  bus_own;

  always_comb begin
    own_sel = last_reg;
    bus_own = 2'b00;
    case (state_reg)
      G0: begin
        own_sel = 1'b0;
        bus_own = 2'b01;
      end
      G1: begin
        own_sel = 1'b1;
        bus_own = 2'b10;
      end
      default: begin
        own_sel = last_reg;
        bus_own = 2'b00;
      end
    endcase
  end

  assign own_cyc = own_sel ? m1.cyc : m0.cyc;

  // ------------------------------------------------------------------
  // Request path: combinational mux selected by the registered state.
  // ------------------------------------------------------------------
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [15:0] bus_adr;
  logic [7:0]  bus_dat;

  always_comb begin
    bus_cyc = 1'b0;
    bus_stb = 1'b0;
    bus_we  = 1'b0;
    bus_adr = 16'h0000;
    bus_dat = 8'h00;
    if (bus_own[0]) begin
      bus_cyc = m0.cyc;
      bus_stb = m0.stb;
      bus_we  = m0.we;
      bus_adr = m0.adr;
      bus_dat = m0.dat_o;
    end else if (bus_own[1]) begin
      bus_cyc = m1.cyc;
      bus_stb = m1.stb;
      bus_we  = m1.we;
      bus_adr = m1.adr;
      bus_dat = m1.dat_o;
    end
  end

  assign wb.cyc   = bus_cyc;
  assign wb.stb   = bus_stb;
  assign wb.we    = bus_we;
  assign wb.adr   = bus_adr;
  assign wb.dat_o = bus_dat;

  // ------------------------------------------------------------------
  // Watchdog (optional)
  // ------------------------------------------------------------------
  logic [1:0] err_pulse;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] CNT_FIRE = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_MAX  = TO_W'(TIMEOUT);

  logic [TO_W-1:0] cnt_reg;
  logic [1:0]      err_reg;
  logic            own_stb;
  logic            fire;

  assign own_stb = own_sel ? m1.stb : m0.stb;
  // An ack landing on the last allowed cycle wins over the watchdog.
  assign fire    = (bus_own != 2'b00) && own_stb && !wb.ack &&
                   (cnt_reg == CNT_FIRE);
  assign err_pulse = err_reg;
`else
  assign err_pulse = 2'b00;
`endif

  // ------------------------------------------------------------------
  // Arbitration FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;   // makes master 0 win the first tie
      gnt_reg   <= 2'b00;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_reg   <= '0;
      err_reg   <= 2'b00;
`endif
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      err_reg <= 2'b00;
`endif
      case (state_reg)
        IDLE: begin
          // On a tie the master that did not own the bus last wins.
          if (m0.cyc && (!m1.cyc || last_reg)) begin
            state_reg <= G0;
            gnt_reg   <= 2'b01;
          end else if (m1.cyc) begin
            state_reg <= G1;
            gnt_reg   <= 2'b10;
          end
`ifdef WB_ARB_TIMEOUT_EN
          cnt_reg <= '0;
`endif
        end

        G0, G1: begin
          if (!own_cyc) begin
            state_reg <= IDLE;
            gnt_reg   <= 2'b00;
            last_reg  <= own_sel;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (fire) begin
            state_reg <= TOUT;
            err_reg   <= gnt_reg;
            last_reg  <= own_sel;
          end
          if (wb.ack || !own_stb) begin
            cnt_reg <= '0;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + TO_W'(1);
          end
`endif
        end

`ifdef WB_ARB_TIMEOUT_EN
        TOUT: begin
          cnt_reg <= '0;
          if (!own_cyc) begin
            state_reg <= IDLE;
            gnt_reg   <= 2'b00;
          end
        end
`endif

        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 2'b00;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Return path: ack/data only to the master the bus is connected to.
  // ------------------------------------------------------------------
  logic [1:0] ret_ack;
  logic [7:0] ret_dat [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      assign ret_ack[gi] = bus_own[gi] & wb.ack;
      assign ret_dat[gi] = bus_own[gi] ? wb.dat_i : 8'h00;
    end
  endgenerate

  assign m0.ack   = ret_ack[0];
  assign m0.dat_i = ret_dat[0];
  assign m0.err   = err_pulse[0];
  assign m1.ack   = ret_ack[1];
  assign m1.dat_i = ret_dat[1];
  assign m1.err   = err_pulse[1];

  assign gnt = gnt_reg;

endmodule
